// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache controller:
// FSM state encoding, line geometry and the tag-width derivation.
package dcache_pkg;

  // Words per cache line and the address bits that select a word in a line.
  localparam int LINE_WORDS  = 4;
  localparam int OFFSET_BITS = 2;

  // Counter value of the last word in a line.
  localparam logic [OFFSET_BITS-1:0] LAST_WORD = OFFSET_BITS'(LINE_WORDS - 1);

  // Controller states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_FILL_REQ,
    S_FILL_WAIT,
    S_COMPLETE
  } state_e;

  // Tag width: everything above index, word offset and the byte bit.
  function automatic int tag_width(input int addr_w, input int index_bits);
    return addr_w - index_bits - OFFSET_BITS - 1;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage for the data cache: valid, dirty, tag and four data words per
// line. One write port (word write plus tag/valid/dirty update at the same
// index) and a combinational read of the whole addressed line.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = 5,
  parameter int DATA_W     = 16,
  parameter int TAG_W      = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [INDEX_BITS-1:0]               index_i,
  input  logic                                word_we_i,
  input  logic [OFFSET_BITS-1:0]              word_sel_i,
  input  logic [DATA_W-1:0]                   word_data_i,
  input  logic                                meta_we_i,
  input  logic                                meta_valid_i,
  input  logic                                meta_dirty_i,
  input  logic [TAG_W-1:0]                    meta_tag_i,
  output logic                                valid_o,
  output logic                                dirty_o,
  output logic [TAG_W-1:0]                    tag_o,
  output logic [LINE_WORDS-1:0][DATA_W-1:0]   words_o
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]                  valid_q;
  logic [LINES-1:0]                  dirty_q;
  logic [TAG_W-1:0]                  tag_q  [LINES];
  logic [LINE_WORDS-1:0][DATA_W-1:0] data_q [LINES];

  // Valid/dirty flags: cleared by reset, updated by a metadata write.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (meta_we_i) begin
      valid_q[index_i] <= meta_valid_i;
      dirty_q[index_i] <= meta_dirty_i;
    end
  end

  // Tag and data arrays: plain write-enabled storage.
  // NOTE: tags and data carry no reset; a cleared valid bit already makes
  // their contents irrelevant, and leaving them unreset lets them map to RAM.
  always_ff @(posedge clk) begin
    if (meta_we_i) begin
      tag_q[index_i] <= meta_tag_i;
    end
    if (word_we_i) begin
      data_q[index_i][word_sel_i] <= word_data_i;
    end
  end

  assign valid_o = valid_q[index_i];
  assign dirty_o = dirty_q[index_i];
  assign tag_o   = tag_q[index_i];
  assign words_o = data_q[index_i];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller. Hits finish
// in the request cycle; misses stall, write back a dirty victim, refill the
// line from pipelined main memory and then complete the access.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = 5,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_en,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              hit,
  output logic              stall,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              mem_busy,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid
);

  localparam int TAG_W = tag_width(ADDR_W, INDEX_BITS);

  // Request address fields.
  logic [OFFSET_BITS-1:0] offset;
  logic [INDEX_BITS-1:0]  index;
  logic [TAG_W-1:0]       req_tag;
  logic                   misaligned;

  assign misaligned = req_addr[0];
  assign offset     = req_addr[OFFSET_BITS:1];
  assign index      = req_addr[INDEX_BITS+OFFSET_BITS:OFFSET_BITS+1];
  assign req_tag    = req_addr[ADDR_W-1:INDEX_BITS+OFFSET_BITS+1];

  // Addressed line as seen through the array read port.
  logic                              line_valid;
  logic                              line_dirty;
  logic [TAG_W-1:0]                  line_tag;
  logic [LINE_WORDS-1:0][DATA_W-1:0] line_words;
  logic                              line_hit;

  assign line_hit = line_valid && (line_tag == req_tag);

  // Array write port, driven from the output process.
  logic                   word_we;
  logic [OFFSET_BITS-1:0] word_sel;
  logic [DATA_W-1:0]      word_data;
  logic                   meta_we;
  logic                   meta_valid;
  logic                   meta_dirty;
  logic [TAG_W-1:0]       meta_tag;

  dcache_array #(
    .INDEX_BITS (INDEX_BITS),
    .DATA_W     (DATA_W),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk          (clk),
    .rst          (rst),
    .index_i      (index),
    .word_we_i    (word_we),
    .word_sel_i   (word_sel),
    .word_data_i  (word_data),
    .meta_we_i    (meta_we),
    .meta_valid_i (meta_valid),
    .meta_dirty_i (meta_dirty),
    .meta_tag_i   (meta_tag),
    .valid_o      (line_valid),
    .dirty_o      (line_dirty),
    .tag_o        (line_tag),
    .words_o      (line_words)
  );

  // FSM state, issue counter (writes in WB, reads in FILL_REQ) and return
  // counter (fill words received).
  state_e                 state_q, state_d;
  logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
  logic [OFFSET_BITS-1:0] rcnt_q, rcnt_d;

  // Events that advance the counters. Returns are only accepted while a
  // fill is outstanding; strays in other states are ignored.
  logic wr_issue;
  logic rd_issue;
  logic ret;

  assign wr_issue = (state_q == S_WB) && !mem_busy;
  assign rd_issue = (state_q == S_FILL_REQ) && !mem_busy;
  assign ret      = mem_rvalid && ((state_q == S_FILL_REQ) || (state_q == S_FILL_WAIT));

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Next-state and counter logic.
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        rcnt_d = '0;
        if (req_en && !misaligned && !line_hit) begin
          state_d = (line_valid && line_dirty) ? S_WB : S_FILL_REQ;
        end
      end
      S_WB: begin
        if (wr_issue) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_WORD) begin
            state_d = S_FILL_REQ;
          end
        end
      end
      S_FILL_REQ, S_FILL_WAIT: begin
        // Reads may still be issuing while the first returns arrive.
        if (rd_issue) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_WORD) begin
            state_d = S_FILL_WAIT;
          end
        end
        if (ret) begin
          rcnt_d = rcnt_q + 1'b1;
          if (rcnt_q == LAST_WORD) begin
            state_d = S_COMPLETE;
          end
        end
      end
      S_COMPLETE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs, memory strobes and array write control. Everything is held
  // quiet while reset is asserted.
  always_comb begin
    rdata      = '0;
    done       = 1'b0;
    hit        = 1'b0;
    stall      = 1'b0;
    err        = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    word_we    = 1'b0;
    word_sel   = offset;
    word_data  = req_wdata;
    meta_we    = 1'b0;
    meta_valid = 1'b1;
    meta_dirty = 1'b0;
    meta_tag   = req_tag;
    if (!rst) begin
      unique case (state_q)
        S_IDLE: begin
          if (req_en) begin
            if (misaligned) begin
              done = 1'b1;
              err  = 1'b1;
            end else if (line_hit) begin
              done = 1'b1;
              hit  = 1'b1;
              if (req_wr) begin
                word_we    = 1'b1;
                meta_we    = 1'b1;
                meta_dirty = 1'b1;
              end else begin
                rdata = line_words[offset];
              end
            end else begin
              stall = 1'b1;
            end
          end
        end
        S_WB: begin
          stall     = 1'b1;
          mem_addr  = {line_tag, index, cnt_q, 1'b0};
          mem_wdata = line_words[cnt_q];
          mem_wr    = !mem_busy;
          // Victim fully written back: the line is clean from here on.
          if (wr_issue && (cnt_q == LAST_WORD)) begin
            meta_we  = 1'b1;
            meta_tag = line_tag;
          end
        end
        S_FILL_REQ, S_FILL_WAIT: begin
          stall = 1'b1;
          if (state_q == S_FILL_REQ) begin
            mem_addr = {req_tag, index, cnt_q, 1'b0};
            mem_rd   = !mem_busy;
          end
          // Each return lands in its word immediately; the last one
          // installs the new tag as a valid, clean line.
          if (ret) begin
            word_we   = 1'b1;
            word_sel  = rcnt_q;
            word_data = mem_rdata;
            if (rcnt_q == LAST_WORD) begin
              meta_we = 1'b1;
            end
          end
        end
        S_COMPLETE: begin
          done = 1'b1;
          if (req_wr) begin
            word_we    = 1'b1;
            meta_we    = 1'b1;
            meta_dirty = 1'b1;
          end else begin
            rdata = line_words[offset];
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl. A pipelined main-memory model with
// fixed read latency answers the controller; a reference model (architectural
// memory image plus per-line valid/dirty/tag) predicts hit/miss, write-back
// traffic, fill addresses, load data and miss latency.
module tb_dcache_ctrl;

  localparam int INDEX_BITS = 5;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int LINES      = 32;
  localparam int MEM_WORDS  = 32768;
  localparam int LAT        = 3;
  localparam int TIMEOUT    = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_en;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [15:0] rdata;
  logic        done;
  logic        hit;
  logic        stall;
  logic        err;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_busy;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;

  dcache_ctrl #(
    .INDEX_BITS (INDEX_BITS),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_en     (req_en),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rdata      (rdata),
    .done       (done),
    .hit        (hit),
    .stall      (stall),
    .err        (err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_busy   (mem_busy),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Main memory seen by the controller, and the architectural image loads
  // must observe (main memory overlaid with every store so far).
  logic [15:0] mem     [MEM_WORDS];
  logic [15:0] ref_mem [MEM_WORDS];

  // Reference cache bookkeeping.
  bit          ref_valid [LINES];
  bit          ref_dirty [LINES];
  logic [7:0]  ref_tag   [LINES];

  typedef struct {
    int waddr;
    int due;
  } rd_t;
  rd_t rq[$];

  logic [15:0] rd_log[$];
  logic [15:0] wr_log[$];
  logic [15:0] wd_log[$];

  logic        s_done, s_hit, s_err, s_stall, s_mem_rd, s_mem_wr;
  logic [15:0] s_rdata;

  // One clock cycle: present memory inputs, sample outputs away from the
  // edge, run the memory model, then advance to the next falling edge.
  task automatic step(input logic busy);
    rd_t e;
    mem_busy = busy;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem[rq[0].waddr];
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 16'($urandom);
    end
    #1;
    total++;
    if ((mem_rd && mem_wr) || ((mem_rd || mem_wr) && (mem_addr[0] || mem_busy))) begin
      bad++;
      $display("FAIL mem_protocol cyc=%0d got rd=%b wr=%b busy=%b addr=%h, need legal strobe",
               cyc, mem_rd, mem_wr, mem_busy, mem_addr);
    end
    if (!rst && mem_rd && !mem_busy) begin
      e.waddr = int'(mem_addr[15:1]);
      e.due   = cyc + LAT;
      rq.push_back(e);
      rd_log.push_back(mem_addr);
    end
    if (!rst && mem_wr && !mem_busy) begin
      mem[mem_addr[15:1]] = mem_wdata;
      wr_log.push_back(mem_addr);
      wd_log.push_back(mem_wdata);
    end
    if (mem_rvalid) void'(rq.pop_front());
    s_done   = done;
    s_hit    = hit;
    s_err    = err;
    s_stall  = stall;
    s_rdata  = rdata;
    s_mem_rd = mem_rd;
    s_mem_wr = mem_wr;
    @(posedge clk);
    if (rst) rq.delete();
    @(negedge clk);
    cyc++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      ref_valid[i] = 1'b0;
      ref_dirty[i] = 1'b0;
    end
  endtask

  // One access from request to done, checked against the reference model.
  // Busy is forced for request-relative cycles busy_lo..busy_hi and, when
  // rand_busy is set, randomly on a quarter of the cycles.
  task automatic do_access(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                           input int busy_lo, input int busy_hi, input bit rand_busy,
                           output int lat);
    logic [4:0]  idx;
    logic [7:0]  tg;
    logic [15:0] a;
    logic [15:0] exp_rd;
    logic [15:0] exp_rda[$];
    logic [15:0] exp_wra[$];
    logic [15:0] exp_wda[$];
    bit exp_hit, exp_err, exp_wb, got_done, stall_ok, busy_used, q_ok;
    int exp_lat, k;
    logic b;

    idx     = addr[7:3];
    tg      = addr[15:8];
    exp_err = addr[0];
    exp_hit = !exp_err && ref_valid[idx] && (ref_tag[idx] == tg);
    exp_wb  = !exp_err && !exp_hit && ref_valid[idx] && ref_dirty[idx];
    exp_rd  = ref_mem[addr[15:1]];
    if (!exp_err && !exp_hit) begin
      for (int j = 0; j < 4; j++) exp_rda.push_back({tg, idx, 2'(j), 1'b0});
    end
    if (exp_wb) begin
      for (int j = 0; j < 4; j++) begin
        a = {ref_tag[idx], idx, 2'(j), 1'b0};
        exp_wra.push_back(a);
        exp_wda.push_back(ref_mem[a[15:1]]);
      end
    end
    exp_lat = (exp_err || exp_hit) ? 0 : (4 + LAT + 1 + (exp_wb ? 4 : 0));

    rd_log.delete();
    wr_log.delete();
    wd_log.delete();
    req_en    = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    k         = 0;
    got_done  = 1'b0;
    stall_ok  = 1'b1;
    busy_used = 1'b0;
    while (!got_done && k < TIMEOUT) begin
      b = ((k >= busy_lo) && (k <= busy_hi)) || (rand_busy && ($urandom_range(0, 3) == 0));
      if (b) busy_used = 1'b1;
      step(b);
      if (s_done) begin
        got_done = 1'b1;
        if (s_stall !== 1'b0) stall_ok = 1'b0;
      end else begin
        if (s_stall !== 1'b1) stall_ok = 1'b0;
        k++;
      end
    end
    req_en = 1'b0;
    lat    = k;

    total++;
    if (!got_done) begin
      bad++;
      $display("FAIL acc_timeout addr=%h got no done in %0d cycles, need done", addr, TIMEOUT);
    end
    total++;
    if (s_err !== exp_err) begin
      bad++;
      $display("FAIL acc_err addr=%h got %b need %b", addr, s_err, exp_err);
    end
    total++;
    if (s_hit !== exp_hit) begin
      bad++;
      $display("FAIL acc_hit addr=%h got %b need %b", addr, s_hit, exp_hit);
    end
    if (!wr && !exp_err) begin
      total++;
      if (s_rdata !== exp_rd) begin
        bad++;
        $display("FAIL acc_rdata addr=%h got %h need %h", addr, s_rdata, exp_rd);
      end
    end
    total++;
    if (!stall_ok) begin
      bad++;
      $display("FAIL acc_stall addr=%h got bad stall shape, need 1 until done then 0", addr);
    end
    q_ok = (rd_log.size() == exp_rda.size());
    if (q_ok) foreach (exp_rda[i]) if (rd_log[i] !== exp_rda[i]) q_ok = 1'b0;
    total++;
    if (!q_ok) begin
      bad++;
      $display("FAIL acc_reads addr=%h got %0d reads first=%h, need %0d first=%h", addr,
               rd_log.size(), (rd_log.size() > 0) ? rd_log[0] : 16'h0,
               exp_rda.size(), (exp_rda.size() > 0) ? exp_rda[0] : 16'h0);
    end
    q_ok = (wr_log.size() == exp_wra.size());
    if (q_ok) foreach (exp_wra[i]) if (wr_log[i] !== exp_wra[i] || wd_log[i] !== exp_wda[i]) q_ok = 1'b0;
    total++;
    if (!q_ok) begin
      bad++;
      $display("FAIL acc_writes addr=%h got %0d writes, need %0d with victim data", addr,
               wr_log.size(), exp_wra.size());
    end
    if (!busy_used && got_done) begin
      total++;
      if (lat != exp_lat) begin
        bad++;
        $display("FAIL acc_latency addr=%h got %0d need %0d", addr, lat, exp_lat);
      end
    end

    if (!exp_err) begin
      if (!exp_hit) begin
        ref_valid[idx] = 1'b1;
        ref_dirty[idx] = 1'b0;
        ref_tag[idx]   = tg;
      end
      if (wr) begin
        ref_dirty[idx]       = 1'b1;
        ref_mem[addr[15:1]]  = wdata;
      end
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    req_en     = 1'b0;
    req_wr     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    mem_busy   = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    @(negedge clk);
    step(1'b0);
    step(1'b0);
    total++;
    if ({s_done, s_hit, s_stall, s_err, s_mem_rd, s_mem_wr} !== 6'b0 || s_rdata !== 16'h0) begin
      bad++;
      $display("FAIL reset_in outputs got %b rdata=%h need all 0",
               {s_done, s_hit, s_stall, s_err, s_mem_rd, s_mem_wr}, s_rdata);
    end
    rst = 1'b0;
    model_reset();
    step(1'b0);
    total++;
    if ({s_done, s_hit, s_stall, s_err, s_mem_rd, s_mem_wr} !== 6'b0 || s_rdata !== 16'h0) begin
      bad++;
      $display("FAIL reset_idle outputs got %b rdata=%h need all 0",
               {s_done, s_hit, s_stall, s_err, s_mem_rd, s_mem_wr}, s_rdata);
    end
  endtask

  task automatic test_cold_load();
    int lat;
    do_access(1'b0, 16'h0010, 16'h0, 1, 0, 1'b0, lat);
    total++;
    if (s_rdata !== 16'hBEEF || s_hit !== 1'b0 || lat != 4 + LAT + 1) begin
      bad++;
      $display("FAIL cold_load got rdata=%h hit=%b lat=%0d need BEEF 0 %0d", s_rdata, s_hit, lat, 4 + LAT + 1);
    end
    total++;
    if (rd_log.size() != 4 || rd_log[0] !== 16'h0010 || rd_log[3] !== 16'h0016) begin
      bad++;
      $display("FAIL cold_reads got %0d reads, need 4 at 0010..0016", rd_log.size());
    end
    do_access(1'b0, 16'h0010, 16'h0, 1, 0, 1'b0, lat);
    total++;
    if (s_hit !== 1'b1 || lat != 0 || s_rdata !== 16'hBEEF) begin
      bad++;
      $display("FAIL reload_hit got hit=%b lat=%0d rdata=%h need 1 0 BEEF", s_hit, lat, s_rdata);
    end
  endtask

  task automatic test_store_hit();
    int lat;
    do_access(1'b1, 16'h0012, 16'h1234, 1, 0, 1'b0, lat);
    total++;
    if (s_hit !== 1'b1 || (rd_log.size() + wr_log.size()) != 0) begin
      bad++;
      $display("FAIL store_hit got hit=%b traffic=%0d need 1 0", s_hit, rd_log.size() + wr_log.size());
    end
    do_access(1'b0, 16'h0012, 16'h0, 1, 0, 1'b0, lat);
    total++;
    if (s_rdata !== 16'h1234) begin
      bad++;
      $display("FAIL store_readback got %h need 1234", s_rdata);
    end
  endtask

  task automatic test_conflict();
    int lat;
    do_access(1'b0, 16'h0112, 16'h0, 1, 0, 1'b0, lat);
    total++;
    if (wr_log.size() != 4 || wr_log[0] !== 16'h0010 || wd_log[1] !== 16'h1234 ||
        rd_log.size() != 4 || rd_log[0] !== 16'h0110 || lat != 4 + 4 + LAT + 1) begin
      bad++;
      $display("FAIL conflict_wb got wr=%0d rd=%0d lat=%0d need 4 writes (0012=1234) 4 reads lat %0d",
               wr_log.size(), rd_log.size(), lat, 4 + 4 + LAT + 1);
    end
    total++;
    if (mem[9] !== 16'h1234) begin
      bad++;
      $display("FAIL conflict_memimg got %h need 1234 at 0012", mem[9]);
    end
    do_access(1'b0, 16'h0012, 16'h0, 1, 0, 1'b0, lat);
    total++;
    if (s_rdata !== 16'h1234) begin
      bad++;
      $display("FAIL conflict_reload got %h need 1234", s_rdata);
    end
  endtask

  task automatic test_misaligned();
    int lat;
    do_access(1'b0, 16'h0013, 16'h0, 1, 0, 1'b0, lat);
    total++;
    if (s_err !== 1'b1 || s_done !== 1'b1 || lat != 0 || (rd_log.size() + wr_log.size()) != 0) begin
      bad++;
      $display("FAIL misaligned got err=%b done=%b lat=%0d need 1 1 0 no traffic", s_err, s_done, lat);
    end
  endtask

  task automatic test_busy();
    int lat;
    do_access(1'b0, 16'h0420, 16'h0, 2, 4, 1'b0, lat);
    total++;
    if (rd_log.size() != 4 || lat != 4 + LAT + 1 + 3) begin
      bad++;
      $display("FAIL busy_fill got reads=%0d lat=%0d need 4 %0d", rd_log.size(), lat, 4 + LAT + 1 + 3);
    end
  endtask

  task automatic test_reset_fill_wait();
    int lat;
    rd_log.delete();
    wr_log.delete();
    wd_log.delete();
    req_en    = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 16'h0530;
    req_wdata = '0;
    for (int k = 0; k < 6; k++) step(1'b0);
    total++;
    if (s_stall !== 1'b1 || s_done !== 1'b0 || rd_log.size() != 4) begin
      bad++;
      $display("FAIL fill_wait_pre got stall=%b done=%b reads=%0d need 1 0 4", s_stall, s_done, rd_log.size());
    end
    rst    = 1'b1;
    req_en = 1'b0;
    step(1'b0);
    rst = 1'b0;
    model_reset();
    step(1'b0);
    total++;
    if ({s_done, s_hit, s_stall, s_err, s_mem_rd, s_mem_wr} !== 6'b0 || s_rdata !== 16'h0) begin
      bad++;
      $display("FAIL reset_abort outputs got %b rdata=%h need all 0",
               {s_done, s_hit, s_stall, s_err, s_mem_rd, s_mem_wr}, s_rdata);
    end
    do_access(1'b0, 16'h0530, 16'h0, 1, 0, 1'b0, lat);
    total++;
    if (s_hit !== 1'b0 || rd_log.size() != 4) begin
      bad++;
      $display("FAIL reset_refetch got hit=%b reads=%0d need 0 4", s_hit, rd_log.size());
    end
  endtask

  task automatic test_random();
    int lat;
    logic [15:0] a;
    for (int n = 0; n < 300; n++) begin
      a = {6'h0, 2'($urandom_range(0, 3)), 2'b0, 3'($urandom_range(0, 7)),
           2'($urandom), 1'($urandom_range(0, 15) == 0)};
      do_access(1'($urandom), a, 16'($urandom), 1, 0, 1'b1, lat);
      if ($urandom_range(0, 7) == 0) begin
        step(1'b0);
        total++;
        if (s_done !== 1'b0 || s_stall !== 1'b0) begin
          bad++;
          $display("FAIL idle_quiet got done=%b stall=%b need 0 0", s_done, s_stall);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem[i]     = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[8]     = 16'hBEEF;
    ref_mem[8] = 16'hBEEF;
    test_reset();
    test_cold_load();
    test_store_hit();
    test_conflict();
    test_misaligned();
    test_busy();
    test_reset_fill_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
